reservation_station: RTL and testbench

- Issue-side consumer of the dispatch interface in the out-of-order core.
- Accepts `dispatch_pipeline_data` packets from the dispatch stage and holds them as `rs_data` entries.
- Wakes operands from the common data bus (CDB) and issues the oldest fully-ready entry to its functional unit over a valid/ready handshake.
- One instance per FU class; dispatch does the routing.

---
 rtl/types_pkg.sv | 35 +++
 rtl/rs_oldest_select.sv | 21 ++
 rtl/reservation_station.sv | 132 +++++++++++++
 tb/tb_reservation_station.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared pipeline types for the issue stage: dispatch packet, reservation-station entry and tag type.
package types_pkg;

   localparam int RS_DEPTH_MAX = 8;

   typedef logic [6:0] preg_t;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [31:0] pc;
      preg_t       prd;
      preg_t       pr1;
      logic        pr1_ready;
      preg_t       pr2;
      logic        pr2_ready;
      logic [31:0] imm;
      logic [5:0]  rob_index;
   } dispatch_pipeline_data;

   typedef struct packed {
      logic        valid;
      logic [2:0]  age;
      logic [1:0]  fu;
      logic [6:0]  opcode;
      logic [31:0] pc;
      preg_t       prd;
      preg_t       pr1;
      logic        pr1_ready;
      preg_t       pr2;
      logic        pr2_ready;
      logic [31:0] imm;
      logic [5:0]  rob_index;
   } rs_data;

endpackage

// File: rtl/rs_oldest_select.sv
// Combinational oldest-first picker: grants the eligible entry with the smallest age (ages are unique).
module rs_oldest_select #(
   parameter int N = 8
) (
   input  logic [N-1:0]      elig,
   input  logic [N-1:0][2:0] age,
   output logic [N-1:0]      grant,
   output logic              any
);

   always_comb begin
      for (int i = 0; i < N; i++) begin
         grant[i] = elig[i];
         for (int j = 0; j < N; j++) begin
            if (j != i && elig[j] && age[j] < age[i]) grant[i] = 1'b0;
         end
      end
      any = |elig;
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops, wakes operands from the CDB, issues oldest ready entry.
// Optional RS_PERF_EN adds perf_stall_cnt (dispatch-stall cycle counter).
module reservation_station
   import types_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  disp_valid,
   output logic                  disp_ready,
   input  dispatch_pipeline_data disp_data,
   input  logic [1:0]            disp_fu,
   input  logic                  cdb_valid,
   input  preg_t                 cdb_tag,
   output logic                  issue_valid,
   input  logic                  issue_ready,
   output rs_data                issue_data,
   input  logic                  flush,
   output logic [3:0]            occupancy
`ifdef RS_PERF_EN
   ,
   output logic [31:0]           perf_stall_cnt
`endif
);

   rs_data                ent [DEPTH];
   rs_data                new_ent;
   logic [DEPTH-1:0]      elig, grant, free_oh;
   logic [DEPTH-1:0][2:0] ages;
   logic                  any, found, issue_fire, disp_fire;
   logic [2:0]            sel_age, new_age;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         elig[i] = ent[i].valid && ent[i].pr1_ready && ent[i].pr2_ready;
         ages[i] = ent[i].age;
      end
   end

   rs_oldest_select #(.N(DEPTH)) u_sel (
      .elig  (elig),
      .age   (ages),
      .grant (grant),
      .any   (any)
   );

   always_comb begin
      issue_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) issue_data = ent[i];
      end
   end

   assign sel_age     = issue_data.age;
   assign issue_valid = any && !flush;
   assign disp_ready  = occupancy < 4'(DEPTH);
   assign issue_fire  = issue_valid && issue_ready;
   assign disp_fire   = disp_valid && disp_ready && !flush;
   // The new entry is younger than every survivor, so it takes the age just past them.
   assign new_age     = 3'(occupancy - {3'b0, issue_fire});

   always_comb begin
      free_oh = '0;
      found   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!ent[i].valid && !found) begin
            free_oh[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // Same-cycle CDB bypass so a broadcast coinciding with allocation is not lost.
   always_comb begin
      new_ent = '{
         valid:     1'b1,
         age:       new_age,
         fu:        disp_fu,
         opcode:    disp_data.opcode,
         pc:        disp_data.pc,
         prd:       disp_data.prd,
         pr1:       disp_data.pr1,
         pr1_ready: disp_data.pr1_ready || disp_data.pr1 == '0 ||
                    (cdb_valid && cdb_tag == disp_data.pr1),
         pr2:       disp_data.pr2,
         pr2_ready: disp_data.pr2_ready || disp_data.pr2 == '0 ||
                    (cdb_valid && cdb_tag == disp_data.pr2),
         imm:       disp_data.imm,
         rob_index: disp_data.rob_index
      };
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
         occupancy <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent[i].valid <= 1'b0;
            ent[i].age   <= '0;
         end
         occupancy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_fire && free_oh[i]) begin
               ent[i] <= new_ent;
            end else if (ent[i].valid) begin
               if (issue_fire && grant[i]) begin
                  ent[i].valid <= 1'b0;
                  ent[i].age   <= '0;
               end else begin
                  if (issue_fire && ent[i].age > sel_age) ent[i].age <= ent[i].age - 3'd1;
                  if (cdb_valid && ent[i].pr1 == cdb_tag) ent[i].pr1_ready <= 1'b1;
                  if (cdb_valid && ent[i].pr2 == cdb_tag) ent[i].pr2_ready <= 1'b1;
               end
            end
         end
         occupancy <= 4'(occupancy + {3'b0, disp_fire} - {3'b0, issue_fire});
      end
   end

`ifdef RS_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_stall_cnt <= '0;
      else if (disp_valid && !disp_ready && perf_stall_cnt != 32'hFFFF_FFFF)
         perf_stall_cnt <= perf_stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (covers RS_PERF_EN when defined).
module tb_reservation_station;
   import types_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  disp_valid, disp_ready;
   dispatch_pipeline_data disp_data;
   logic [1:0]            disp_fu;
   logic                  cdb_valid;
   preg_t                 cdb_tag;
   logic                  issue_valid, issue_ready;
   rs_data                issue_data;
   logic                  flush;
   logic [3:0]            occupancy;
`ifdef RS_PERF_EN
   logic [31:0]           perf_stall_cnt;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   reservation_station #(.DEPTH(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .disp_valid  (disp_valid),
      .disp_ready  (disp_ready),
      .disp_data   (disp_data),
      .disp_fu     (disp_fu),
      .cdb_valid   (cdb_valid),
      .cdb_tag     (cdb_tag),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_data  (issue_data),
      .flush       (flush),
      .occupancy   (occupancy)
`ifdef RS_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input preg_t p1, input logic r1, input preg_t p2, input logic r2,
                       input logic [5:0] rob);
      disp_valid          = 1'b1;
      disp_data           = '0;
      disp_data.opcode    = 7'h33;
      disp_data.pc        = {24'h0, rob, 2'b00};
      disp_data.prd       = 7'd100;
      disp_data.pr1       = p1;
      disp_data.pr1_ready = r1;
      disp_data.pr2       = p2;
      disp_data.pr2_ready = r2;
      disp_data.rob_index = rob;
      disp_fu             = 2'd1;
   endtask

   initial begin
      rst_n = 1'b0; disp_valid = 1'b0; disp_data = '0; disp_fu = '0;
      cdb_valid = 1'b0; cdb_tag = '0; issue_ready = 1'b0; flush = 1'b0;
      #3;
      check("rst_occ", 128'(occupancy), 128'd0);
      check("rst_issue_valid", 128'(issue_valid), 128'd0);
      check("rst_disp_ready", 128'(disp_ready), 128'd1);
      check("rst_issue_data", 128'(issue_data), 128'd0);
      #19 rst_n = 1'b1;
      tick();

      // Ready dispatch issues one cycle later with age 0
      disp(7'd5, 1'b1, 7'd6, 1'b1, 6'd3);
      tick();
      disp_valid = 1'b0;
      check("t1_issue_valid", 128'(issue_valid), 128'd1);
      check("t1_rob", 128'(issue_data.rob_index), 128'd3);
      check("t1_age", 128'(issue_data.age), 128'd0);
      check("t1_occ1", 128'(occupancy), 128'd1);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("t1_occ0", 128'(occupancy), 128'd0);
      check("t1_idle", 128'(issue_valid), 128'd0);

      // Bypass at allocation; pr2 = x0 counts as ready
      disp(7'd12, 1'b0, 7'd0, 1'b0, 6'd9);
      cdb_valid = 1'b1; cdb_tag = 7'd12;
      tick();
      disp_valid = 1'b0; cdb_valid = 1'b0;
      check("t2_issue_valid", 128'(issue_valid), 128'd1);
      check("t2_rob", 128'(issue_data.rob_index), 128'd9);
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      check("t2_occ0", 128'(occupancy), 128'd0);

      // Wakeup order: fill 8, wake ages 2 and 5
      for (int i = 0; i < 8; i++) begin
         disp((i == 2 || i == 5) ? 7'd40 : 7'(20 + i), 1'b0, 7'd1, 1'b1, 6'(16 + i));
         tick();
      end
      disp_valid = 1'b0;
      check("t3_occ8", 128'(occupancy), 128'd8);
      check("t3_full", 128'(disp_ready), 128'd0);
      check("t3_none", 128'(issue_valid), 128'd0);
      cdb_valid = 1'b1; cdb_tag = 7'd40; issue_ready = 1'b1;
      tick();
      cdb_valid = 1'b0;
      check("t3_first_valid", 128'(issue_valid), 128'd1);
      check("t3_first_rob", 128'(issue_data.rob_index), 128'd18);
      check("t3_first_age", 128'(issue_data.age), 128'd2);
      tick();
      check("t3_occ7", 128'(occupancy), 128'd7);
      check("t3_ready_again", 128'(disp_ready), 128'd1);
      check("t3_second_valid", 128'(issue_valid), 128'd1);
      check("t3_second_rob", 128'(issue_data.rob_index), 128'd21);
      check("t3_second_age", 128'(issue_data.age), 128'd4);
      tick();
      issue_ready = 1'b0;
      check("t3_occ6", 128'(occupancy), 128'd6);
      check("t3_drained", 128'(issue_valid), 128'd0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t3_flush_occ", 128'(occupancy), 128'd0);

      // Simultaneous dispatch and issue at occupancy 3
      disp(7'd1, 1'b1, 7'd2, 1'b1, 6'd30); tick();
      disp(7'd50, 1'b0, 7'd2, 1'b1, 6'd31); tick();
      disp(7'd51, 1'b0, 7'd2, 1'b1, 6'd32); tick();
      check("t4_occ3", 128'(occupancy), 128'd3);
      check("t4_rob30", 128'(issue_data.rob_index), 128'd30);
      disp(7'd52, 1'b0, 7'd2, 1'b1, 6'd33);
      issue_ready = 1'b1;
      tick();
      disp_valid = 1'b0; issue_ready = 1'b0;
      check("t4_occ_kept", 128'(occupancy), 128'd3);
      check("t4_none_ready", 128'(issue_valid), 128'd0);
      cdb_valid = 1'b1; cdb_tag = 7'd52;
      tick();
      cdb_valid = 1'b0;
      check("t4_new_valid", 128'(issue_valid), 128'd1);
      check("t4_new_rob", 128'(issue_data.rob_index), 128'd33);
      check("t4_new_age", 128'(issue_data.age), 128'd2);
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // Flush with pending dispatch and issue handshakes
      for (int i = 0; i < 5; i++) begin
         disp(7'd3, 1'b1, 7'd4, 1'b1, 6'(40 + i));
         tick();
      end
      disp_valid = 1'b0;
      check("t5_occ5", 128'(occupancy), 128'd5);
      check("t5_oldest", 128'(issue_data.rob_index), 128'd40);
      disp(7'd3, 1'b1, 7'd4, 1'b1, 6'd45);
      issue_ready = 1'b1; flush = 1'b1;
      #1;
      check("t5_flush_issue_valid", 128'(issue_valid), 128'd0);
      tick();
      disp_valid = 1'b0; issue_ready = 1'b0; flush = 1'b0;
      check("t5_occ0", 128'(occupancy), 128'd0);
      check("t5_not_stored", 128'(issue_valid), 128'd0);

`ifdef RS_PERF_EN
      check("t6_cnt0", 128'(perf_stall_cnt), 128'd0);
      for (int i = 0; i < 8; i++) begin
         disp(7'(60 + i), 1'b0, 7'd2, 1'b1, 6'(i));
         tick();
      end
      for (int i = 0; i < 4; i++) tick();
      disp_valid = 1'b0;
      check("t6_cnt4", 128'(perf_stall_cnt), 128'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      check("t6_cnt_after_flush", 128'(perf_stall_cnt), 128'd4);
      check("t6_occ0", 128'(occupancy), 128'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
